// File: rtl/ray_scheduler.sv
// Frame ray sequencer: walks pixels and samples and issues one ray per available credit.
// Defining RAY_SCHED_PERF_EN adds the stall_cycles output and its counter.
module ray_scheduler #(
    parameter int unsigned WIDTH   = 1280,
    parameter int unsigned HEIGHT  = 720,
    parameter int unsigned SAMPLES = 1,
    parameter int unsigned CREDITS = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_start,
    input  logic                         frame_abort,
    input  logic                         ray_done,
    output logic                         new_ray,
    output logic [10:0]                  pixel_h,
    output logic [9:0]                   pixel_v,
    output logic [7:0]                   sample_idx,
    output logic                         busy,
    output logic                         frame_done,
    output logic [15:0]                  frame_count,
    output logic [$clog2(CREDITS+1)-1:0] credits_avail
`ifdef RAY_SCHED_PERF_EN
    ,
    output logic [31:0]                  stall_cycles
`endif
);

    localparam int unsigned CW = $clog2(CREDITS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [10:0]   h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic [7:0]    s_q, s_d;
    logic          new_ray_q, new_ray_d;
    logic [10:0]   pix_h_q, pix_h_d;
    logic [9:0]    pix_v_q, pix_v_d;
    logic [7:0]    samp_q, samp_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   count_q, count_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          aborted_q, aborted_d;
    logic          issue;
`ifdef RAY_SCHED_PERF_EN
    logic [31:0]   stall_q, stall_d;
`endif

    // Next-state, counter walk and credit accounting
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        s_d       = s_q;
        pix_h_d   = pix_h_q;
        pix_v_d   = pix_v_q;
        samp_d    = samp_q;
        count_d   = count_q;
        credits_d = credits_q;
        aborted_d = aborted_q;
        issue     = 1'b0;
`ifdef RAY_SCHED_PERF_EN
        stall_d   = stall_q;
`endif

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    h_d     = '0;
                    v_d     = '0;
                    s_d     = '0;
                    state_d = ISSUE;
`ifdef RAY_SCHED_PERF_EN
                    stall_d = '0;
`endif
                end
            end
            ISSUE: begin
`ifdef RAY_SCHED_PERF_EN
                if (credits_q == '0 && stall_q != 32'hFFFF_FFFF) begin
                    stall_d = stall_q + 32'd1;
                end
`endif
                if (frame_abort) begin
                    state_d   = DRAIN;
                    aborted_d = 1'b1;
                end else if (credits_q != '0) begin
                    issue   = 1'b1;
                    pix_h_d = h_q;
                    pix_v_d = v_q;
                    samp_d  = s_q;
                    if (s_q == 8'(SAMPLES - 1)) begin
                        s_d = '0;
                        if (h_q == 11'(WIDTH - 1)) begin
                            h_d = '0;
                            if (v_q == 10'(HEIGHT - 1)) begin
                                v_d     = '0;
                                state_d = DRAIN;
                            end else begin
                                v_d = v_q + 10'd1;
                            end
                        end else begin
                            h_d = h_q + 11'd1;
                        end
                    end else begin
                        s_d = s_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                if (credits_q == CW'(CREDITS)) begin
                    state_d = DONE;
                    if (!aborted_q) begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                aborted_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A returned credit only becomes usable on the following cycle
        if (issue && !ray_done) begin
            credits_d = credits_q - CW'(1);
        end else if (!issue && ray_done && credits_q != CW'(CREDITS)) begin
            credits_d = credits_q + CW'(1);
        end

        new_ray_d = issue;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            h_q       <= '0;
            v_q       <= '0;
            s_q       <= '0;
            new_ray_q <= 1'b0;
            pix_h_q   <= '0;
            pix_v_q   <= '0;
            samp_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            credits_q <= CW'(CREDITS);
            aborted_q <= 1'b0;
`ifdef RAY_SCHED_PERF_EN
            stall_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            s_q       <= s_d;
            new_ray_q <= new_ray_d;
            pix_h_q   <= pix_h_d;
            pix_v_q   <= pix_v_d;
            samp_q    <= samp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            count_q   <= count_d;
            credits_q <= credits_d;
            aborted_q <= aborted_d;
`ifdef RAY_SCHED_PERF_EN
            stall_q   <= stall_d;
`endif
        end
    end

    assign new_ray       = new_ray_q;
    assign pixel_h       = pix_h_q;
    assign pixel_v       = pix_v_q;
    assign sample_idx    = samp_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign frame_count   = count_q;
    assign credits_avail = credits_q;
`ifdef RAY_SCHED_PERF_EN
    assign stall_cycles  = stall_q;
`endif

endmodule

// File: tb/tb_ray_scheduler.sv
// Self-checking bench for ray_scheduler: queue-based frame model compared every cycle.
`timescale 1ns/1ps
module tb_ray_scheduler;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned S  = 2;
    localparam int unsigned C  = 4;
    localparam int unsigned CW = $clog2(C + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          frame_abort = 1'b0;
    logic          man_done = 1'b0;
    logic          loop_en = 1'b0;
    logic          ray_done;
    logic          new_ray;
    logic [10:0]   pixel_h;
    logic [9:0]    pixel_v;
    logic [7:0]    sample_idx;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic [CW-1:0] credits_avail;
`ifdef RAY_SCHED_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    ray_scheduler #(.WIDTH(W), .HEIGHT(H), .SAMPLES(S), .CREDITS(C)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_abort(frame_abort),
        .ray_done(ray_done), .new_ray(new_ray), .pixel_h(pixel_h), .pixel_v(pixel_v),
        .sample_idx(sample_idx), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .credits_avail(credits_avail)
`ifdef RAY_SCHED_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Downstream pipeline stand-in: fixed 33-cycle return path
    logic [32:0] dly;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly <= '0;
        else        dly <= {dly[31:0], new_ray};
    end
    assign ray_done = (loop_en & dly[32]) | man_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [28:0] seen[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame is a queue of rays; credits are a plain counter
    int          m_mode;     // 0 idle, 1 issuing, 2 draining, 3 done
    logic [28:0] m_q[$];
    int          m_credits;
    bit          m_aborted;
    bit          m_new_ray, m_done, m_busy;
    logic [10:0] m_h;
    logic [9:0]  m_v;
    logic [7:0]  m_s;
    int          m_count;
    logic [31:0] m_stall;

    task automatic model_reset();
        m_mode = 0; m_q.delete(); m_credits = C; m_aborted = 0;
        m_new_ray = 0; m_done = 0; m_busy = 0;
        m_h = '0; m_v = '0; m_s = '0; m_count = 0; m_stall = '0;
    endtask

    task automatic model_step();
        bit iss = 0;
        bit rd = ray_done;
        case (m_mode)
            0: if (frame_start) begin
                m_q.delete();
                for (int v = 0; v < H; v++)
                    for (int h = 0; h < W; h++)
                        for (int s = 0; s < S; s++)
                            m_q.push_back({11'(h), 10'(v), 8'(s)});
                m_mode = 1;
                m_stall = '0;
            end
            1: begin
                if (m_credits == 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
                if (frame_abort) begin
                    m_mode = 2; m_aborted = 1;
                end else if (m_credits != 0) begin
                    iss = 1;
                    {m_h, m_v, m_s} = m_q.pop_front();
                    if (m_q.size() == 0) m_mode = 2;
                end
            end
            2: if (m_credits == C) m_mode = 3;
            default: begin m_mode = 0; m_aborted = 0; end
        endcase
        if (iss && !rd) m_credits--;
        else if (!iss && rd && m_credits < C) m_credits++;
        m_new_ray = iss;
        m_done = (m_mode == 3);
        if (m_mode == 3 && !m_aborted) m_count = (m_count + 1) % 65536;
        m_busy = (m_mode != 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("new_ray", 64'(new_ray), 64'(m_new_ray));
                check("pixel_h", 64'(pixel_h), 64'(m_h));
                check("pixel_v", 64'(pixel_v), 64'(m_v));
                check("sample_idx", 64'(sample_idx), 64'(m_s));
                check("busy", 64'(busy), 64'(m_busy));
                check("frame_done", 64'(frame_done), 64'(m_done));
                check("frame_count", 64'(frame_count), 64'(m_count));
                check("credits_avail", 64'(credits_avail), 64'(m_credits));
`ifdef RAY_SCHED_PERF_EN
                check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
                if (new_ray) seen.push_back({pixel_h, pixel_v, sample_idx});
                if (frame_done) done_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1; tick(1); frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin tick(1); k++; end
        if (busy) check("wait_idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic wait_rays(input int n, input int budget);
        int k = 0;
        while (seen.size() < n && k < budget) begin tick(1); k++; end
        if (seen.size() < n) check("wait_rays_timeout", 64'(seen.size()), 64'(n));
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0; tick(3);
        check("rst_new_ray", 64'(new_ray), 64'(0));
        check("rst_pixel", 64'({pixel_h, pixel_v, sample_idx}), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done_count", 64'({frame_done, frame_count}), 64'(0));
        check("rst_credits", 64'(credits_avail), 64'(4));
        rst_n = 1'b1; tick(5);
        check("post_rst_idle", 64'({new_ray, busy, credits_avail}), 64'(4));

        // Full frame with loopback
        loop_en = 1'b1; seen.delete(); done_cnt = 0;
        pulse_start();
        wait_idle(400);
        check("frame_rays", 64'(seen.size()), 64'(16));
        foreach (seen[i])
            check("frame_order", 64'(seen[i]), 64'({11'((i / 2) % 4), 10'(i / 8), 8'(i % 2)}));
        check("frame_done_once", 64'(done_cnt), 64'(1));
        check("frame_count_1", 64'(frame_count), 64'(1));
        check("frame_busy_0", 64'(busy), 64'(0));

        // Credit exhaustion, then single credit returns
        loop_en = 1'b0; seen.delete();
        pulse_start(); tick(20);
        check("starve_rays", 64'(seen.size()), 64'(4));
        check("starve_credits", 64'(credits_avail), 64'(0));
        man_done = 1'b1; tick(1); man_done = 1'b0; tick(10);
        check("one_more_rays", 64'(seen.size()), 64'(5));
        if (seen.size() >= 5) check("fifth_ray", 64'(seen[4]), 64'({11'd2, 10'd0, 8'd0}));
        man_done = 1'b1; tick(1);
        check("cred_one", 64'(credits_avail), 64'(1));
        tick(1); man_done = 1'b0;
        check("coincide_credits", 64'(credits_avail), 64'(1));
        check("coincide_rays", 64'(seen.size()), 64'(6));
        tick(1);
        check("continue_rays", 64'(seen.size()), 64'(7));
        man_done = 1'b1; wait_idle(200); tick(3);
        check("excess_done_credits", 64'(credits_avail), 64'(4));
        man_done = 1'b0;
        check("frame_count_2", 64'(frame_count), 64'(2));

        // Abort after the third ray
        seen.delete(); done_cnt = 0;
        pulse_start(); wait_rays(3, 50);
        frame_abort = 1'b1; tick(1); frame_abort = 1'b0; tick(10);
        check("abort_rays", 64'(seen.size()), 64'(3));
        check("abort_busy", 64'(busy), 64'(1));
        pulse_start(); tick(3);
        check("start_ignored_rays", 64'(seen.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin man_done = 1'b1; tick(1); man_done = 1'b0; tick(1); end
        wait_idle(20);
        check("abort_done_once", 64'(done_cnt), 64'(1));
        check("abort_count_held", 64'(frame_count), 64'(2));

        // Asynchronous reset mid-frame
        loop_en = 1'b1; seen.delete();
        pulse_start(); wait_rays(3, 50);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        check("async_new_ray", 64'(new_ray), 64'(0));
        check("async_pixel", 64'({pixel_h, pixel_v, sample_idx}), 64'(0));
        check("async_busy_count", 64'({busy, frame_count}), 64'(0));
        check("async_credits", 64'(credits_avail), 64'(4));
        tick(2); rst_n = 1'b1; tick(2);
        seen.delete();
        pulse_start(); wait_rays(1, 20);
        if (seen.size() >= 1) check("restart_first", 64'(seen[0]), 64'(0));
        wait_idle(400);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            frame_start = ($urandom_range(0, 19) == 0);
            frame_abort = ($urandom_range(0, 199) == 0);
            man_done    = ($urandom_range(0, 15) == 0);
            loop_en     = ((cyc / 500) % 2 == 0);
            tick(1);
        end
        frame_start = 1'b0; frame_abort = 1'b0;
        man_done = 1'b1; wait_idle(300); man_done = 1'b0; tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
